arbitro_registro_rr: RTL and testbench

//   Round-robin arbiter and sequencer for one shared DATA_W-bit D flip-flop register.
//   NUM_REQ requesters compete for it; only the granted requester's data is written.

---
 rtl/arbitro_registro_rr.sv | 108 ++++++++++
 tb/tb_arbitro_registro_rr.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/arbitro_registro_rr.sv
// Round-robin arbiter in front of one shared DATA_W-bit register.
// state | meaning: IDLE = waiting for req | GRANT = one-cycle grant, write at close | GAP = forced idle spacing
module arbitro_registro_rr #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int MIN_GAP = 1,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         q,
    output logic                      q_upd,
    output logic [IDX_W-1:0]          owner,
    output logic                      busy
);

    localparam int GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int GAP_LOAD = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   sel;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;
    logic               found;

    // first active request at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            q       <= '0;
            q_upd   <= 1'b0;
            owner   <= '0;
            busy    <= 1'b0;
            ptr     <= '0;
            sel     <= '0;
            gap_cnt <= '0;
        end else begin
            q_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= '0;
                        gnt[pick] <= 1'b1;
                        sel      <= pick;
                        state    <= GRANT;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    // a requester that dropped req during its grant forfeits the write
                    if (req[sel]) begin
                        q     <= din[sel*DATA_W +: DATA_W];
                        owner <= sel;
                        q_upd <= 1'b1;
                    end
                    ptr <= IDX_W'((int'(sel) + 1) % NUM_REQ);
                    if (MIN_GAP > 0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_W'(GAP_LOAD);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_registro_rr.sv
// Directed bench for arbitro_registro_rr: default build plus a MIN_GAP=0 build.
module tb_arbitro_registro_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req0;
    logic [31:0] din, din0;
    logic [3:0]  gnt, gnt0;
    logic [7:0]  q, q0;
    logic        q_upd, q_upd0;
    logic [1:0]  owner, owner0;
    logic        busy, busy0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arbitro_registro_rr dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt), .q(q), .q_upd(q_upd), .owner(owner), .busy(busy)
    );

    arbitro_registro_rr #(.MIN_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .din(din0),
        .gnt(gnt0), .q(q0), .q_upd(q_upd0), .owner(owner0), .busy(busy0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait for a grant to requester k, then check the write on the following cycle
    task automatic grant_check(input string tag, input int k, input logic [7:0] data);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            if (gnt != 4'b0) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_gnt"}, 32'(gnt), 32'd1 << k);
        step();
        check({tag, "_q"}, 32'(q), 32'(data));
        check({tag, "_owner"}, 32'(owner), 32'(k));
        check({tag, "_qupd"}, 32'(q_upd), 32'd1);
    endtask

    logic [3:0] exp_gnt3 [13];
    logic [3:0] exp_gnt6 [8];
    logic       seen5;

    initial begin
        exp_gnt3 = '{4'b0001, 4'b0, 4'b0, 4'b0010, 4'b0, 4'b0, 4'b0100, 4'b0, 4'b0,
                     4'b1000, 4'b0, 4'b0, 4'b0001};
        exp_gnt6 = '{4'b0001, 4'b0, 4'b0010, 4'b0, 4'b0001, 4'b0, 4'b0010, 4'b0};

        rst_n = 1'b0;
        req   = 4'b0;
        din   = 32'h0;
        req0  = 4'b0;
        din0  = 32'h4433_2211;
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_qupd", 32'(q_upd), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // single request from requester 2
        req = 4'b0100;
        din[2*8 +: 8] = 8'hA5;
        step();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_qupd_early", 32'(q_upd), 32'd0);
        step();
        check("t2_q", 32'(q), 32'hA5);
        check("t2_owner", 32'(owner), 32'd2);
        check("t2_qupd", 32'(q_upd), 32'd1);
        check("t2_gnt_off", 32'(gnt), 32'd0);
        req = 4'b0;
        step();
        check("t2_qupd_off", 32'(q_upd), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // reset in the middle of a grant to requester 0 (ptr=3 wraps to 0)
        req = 4'b0001;
        din[0 +: 8] = 8'h77;
        step();
        check("t1_gnt", 32'(gnt), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t1_gnt", 32'(gnt), 32'd0);
        check("t1_q", 32'(q), 32'd0);
        check("t1_owner", 32'(owner), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        req = 4'b0;
        step();
        check("t1_nowrite", 32'(q), 32'd0);
        rst_n = 1'b1;
        step();

        // all four requesting from ptr=0
        din = 32'h4433_2211;
        req = 4'b1111;
        for (int c = 1; c <= 13; c++) begin
            step();
            check($sformatf("t3_gnt_c%0d", c), 32'(gnt), 32'(exp_gnt3[c-1]));
            check($sformatf("t3_busy_c%0d", c), 32'(busy), (c % 3 != 0) ? 32'd1 : 32'd0);
        end
        step();
        check("t3_q", 32'(q), 32'h11);
        check("t3_owner", 32'(owner), 32'd0);
        check("t3_qupd", 32'(q_upd), 32'd1);

        // ptr=1 with req 1001 -> 3, then wrap to 0, then back to 3
        req = 4'b1001;
        grant_check("t4a", 3, 8'h44);
        grant_check("t4b", 0, 8'h11);
        grant_check("t4c", 3, 8'h44);
        req = 4'b0;
        step();

        // requester 1 drops req during its grant cycle
        din[1*8 +: 8] = 8'h3C;
        req = 4'b0010;
        seen5 = 1'b0;
        for (int n = 0; n < 10 && !seen5; n++) begin
            step();
            if (gnt != 4'b0) seen5 = 1'b1;
        end
        check("t5_seen", 32'(seen5), 32'd1);
        check("t5_gnt", 32'(gnt), 32'h2);
        req = 4'b0;
        step();
        check("t5_q", 32'(q), 32'h44);
        check("t5_owner", 32'(owner), 32'd3);
        check("t5_qupd", 32'(q_upd), 32'd0);
        step();
        din[2*8 +: 8] = 8'h5A;
        req = 4'b0111;
        grant_check("t5_ptr", 2, 8'h5A);
        req = 4'b0;
        step();

        // no gap: grants to 0 and 1 alternate every two cycles
        req0 = 4'b0011;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("t6_gnt_c%0d", c), 32'(gnt0), 32'(exp_gnt6[c-1]));
            check($sformatf("t6_busy_c%0d", c), 32'(busy0), (c % 2 == 1) ? 32'd1 : 32'd0);
        end
        check("t6_q", 32'(q0), 32'h22);
        check("t6_owner", 32'(owner0), 32'd1);
        check("t6_qupd", 32'(q_upd0), 32'd1);
        req0 = 4'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
